// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, size defaults and clock constant for the UART playback sequencer
package uart_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int CLK_HZ     = 50_000_000;
    typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, GAP} state_t;
endpackage

// File: rtl/dparm_ram.sv
// dparm_ram: single-write-port buffer with a registered, resettable read port
module dparm_ram
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_ff @(posedge clk)
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/uart_dparm_seq.sv
// uart_dparm_seq: buffers received UART bytes and plays them back once or in a loop on a key press
module uart_dparm_seq
    import uart_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int GAP_CYC = 5000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_done,
    input  logic                       key_flag,
    input  logic                       key_state,
    input  logic                       mode,
    input  logic                       clr,
    input  logic                       tx_done,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       send_en,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP_CYC + 1);

    state_t        state, state_nx;
    logic [CW-1:0] ridx, count_nx;
    logic [GW-1:0] gap_cnt;
    logic          mode_l, stop_req, press, idle, wr, last, gap_end;

    assign press    = key_flag & ~key_state;
    assign idle     = state == IDLE;
    assign wr       = idle & rx_done & (clr | ~full);
    // count_nx already reflects a same-cycle clear and write, so a press sees the new fill level
    assign count_nx = (idle & clr) ? CW'(wr) : count + CW'(wr);
    assign last     = ridx >= count - CW'(1);
    assign gap_end  = gap_cnt == GW'(GAP_CYC - 1);
    assign full     = count == CW'(DEPTH);
    assign busy     = ~idle;
    assign send_en  = state == FIRE;

    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = (press && count_nx != '0) ? LOAD : IDLE;
            LOAD:    state_nx = FIRE;
            FIRE:    state_nx = WAIT;
            WAIT:    state_nx = !tx_done ? WAIT : stop_req ? IDLE : !last ? LOAD : mode_l ? GAP : IDLE;
            GAP:     state_nx = stop_req ? IDLE : gap_end ? LOAD : GAP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
            ridx     <= '0;
            gap_cnt  <= '0;
            mode_l   <= 1'b0;
            stop_req <= 1'b0;
        end else begin
            count    <= count_nx;
            overflow <= (idle & clr) ? 1'b0 : overflow | (rx_done & ~wr);
            mode_l   <= (idle & press) ? mode : mode_l;
            gap_cnt  <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            stop_req <= (state_nx == IDLE) ? 1'b0 : stop_req | (~idle & press);
            if ((idle & press) | (state == GAP & gap_end)) ridx <= '0;
            else if (state == WAIT & tx_done) ridx <= ridx + CW'(1);
        end
    end

    dparm_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr),
        .waddr (clr ? AW'(0) : count[AW-1:0]),
        .wdata (rx_data),
        .re    (state == LOAD),
        .raddr (ridx[AW-1:0]),
        .rdata (tx_data)
    );
endmodule

// File: doc/uart_dparm_seq.md
UART_DPARM_SEQ -- requirements
Module: uart_dparm_seq

Interface
REQ-001 Parameter DATA_W, default 8, byte width of each buffered item.
REQ-002 Parameter DEPTH, default 16, number of buffer entries; power of two, at least 2.
REQ-003 Parameter GAP_CYC, default 5000, idle clocks inserted between loop passes.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 rx_data  input  DATA_W  byte from the UART receiver; valid when rx_done=1.
REQ-007 rx_done  input  1  one-clock pulse marking a received byte.
REQ-008 key_flag  input  1  one-clock pulse from the debouncer on a key edge.
REQ-009 key_state  input  1  debounced key level; 0 = pressed.
REQ-010 mode  input  1  playback mode: 0 = single pass, 1 = continuous loop; sampled at playback start.
REQ-011 clr  input  1  one-clock pulse that empties the buffer.
REQ-012 tx_done  input  1  one-clock pulse from the UART sender when a byte completes.
REQ-013 tx_data  output  DATA_W  byte presented to the UART sender.
REQ-014 send_en  output  1  one-clock pulse that starts a sender transfer.
REQ-015 busy  output  1  high in every state other than IDLE.
REQ-016 count  output  log2(DEPTH)+1  number of stored bytes.
REQ-017 full  output  1  high when count equals DEPTH.
REQ-018 overflow  output  1  sticky flag for a dropped received byte.

Function
REQ-019 The state machine SHALL have the states IDLE, LOAD, FIRE, WAIT and GAP.
REQ-020 In IDLE, rx_done with full=0 SHALL write rx_data at index count and increment count on the next clock.
REQ-021 In IDLE, rx_done with full=1 SHALL drop the byte and set overflow.
REQ-022 Outside IDLE, rx_done SHALL drop the byte and set overflow.
REQ-023 A press is defined as key_flag=1 with key_state=0; key release edges SHALL be ignored.
REQ-024 A press in IDLE with count>0 (count after any same-cycle write) SHALL latch mode, clear the read index, and move to LOAD.
REQ-025 A press in IDLE with count=0 SHALL be ignored.
REQ-026 LOAD SHALL register buffer[read index] into tx_data in one clock, then move to FIRE.
REQ-027 FIRE SHALL assert send_en for exactly one clock, then move to WAIT.
REQ-028 send_en SHALL therefore occur 2 clocks after the press, or after the preceding tx_done or GAP end.
REQ-029 In WAIT, tx_done SHALL increment the read index.
REQ-030 On tx_done, if the read index is below count-1, the state SHALL return to LOAD.
REQ-031 On tx_done after the last byte with latched mode=0, the state SHALL return to IDLE with the buffer retained.
REQ-032 On tx_done after the last byte with latched mode=1, the state SHALL enter GAP, count GAP_CYC clocks, then restart at index 0 in LOAD.
REQ-033 A press while busy SHALL set a stop request.
REQ-034 A pending stop request SHALL return the state to IDLE at the next tx_done or in GAP; the current byte SHALL always complete.
REQ-035 clr in IDLE SHALL zero count and overflow; clr while busy SHALL be ignored.
REQ-036 clr and rx_done together in IDLE SHALL give count=1 with the new byte at index 0.
REQ-037 tx_done outside WAIT SHALL be ignored.

Reset
REQ-038 With rst_n=0 at a clk edge, the block SHALL enter IDLE.
REQ-039 Reset SHALL set count=0, tx_data=0, send_en=0, overflow=0, busy=0, full=0, read index=0 and the stop request=0.
REQ-040 Buffer contents SHALL NOT be reset.
REQ-041 Reset asserted mid-playback SHALL suppress any further send_en from the next clock.

Structure
REQ-042 A shared package uart_pkg SHALL hold the state encoding, the DATA_W/DEPTH defaults and the 50 MHz clock constant.
REQ-043 The buffer SHALL be a sub-module, dparm_ram: single write port, registered read port, DEPTH x DATA_W.

Verification
REQ-044 Bench SHALL drive rx bytes AA,55,33,AF then a press with mode=0 -> four send_en pulses with tx_data AA,55,33,AF in order, then busy=0 and count=4.
REQ-045 Bench SHALL repeat the playback with mode=1 and GAP_CYC=5000, then press during the 2nd pass at byte 33 -> byte 33 completes, no further send_en, IDLE.
REQ-046 Bench SHALL send 17 bytes with DEPTH=16 -> count=16, full=1, overflow=1, byte 17 absent on playback.
REQ-047 Bench SHALL press with count=0 -> busy stays 0 and no send_en is produced.
REQ-048 Bench SHALL pulse rx_done while busy, then clr -> overflow=1, count unchanged until clr, then count=0 and overflow=0.
REQ-049 Bench SHALL assert rst_n=0 in WAIT -> IDLE, count=0, no send_en after reset release without a new press.
